// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole game controller feeding the square-grid renderer.
// Picks target cells per round from an 8-bit Galois LFSR, runs the round and
// reveal timers, and keeps saturating hit/miss totals over a fixed number of rounds.
// Optional build macro MOLE_FREERUN_LFSR_EN: the LFSR steps on every clock
// instead of only when a round is spawned.
module mole_game_ctrl #(
    parameter int unsigned TICK_DIV     = 1000000,
    parameter int unsigned ROUND_TICKS  = 150,
    parameter int unsigned REVEAL_TICKS = 50,
    parameter int unsigned ROUNDS       = 16,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST_BTN,
    input  logic       start,
    input  logic [7:0] btn,
    output logic [7:0] random_num,
    output logic [7:0] hit,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [7:0] round_idx,
    output logic       game_over
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SPAWN, ACTIVE, REVEAL, GAMEOVER} state_t;

    state_t        state;
    logic          start_s1, start_s2, start_prev;
    logic [7:0]    btn_s1, btn_s2, btn_prev;
    logic          start_edge;
    logic [7:0]    press;
    logic [7:0]    lfsr, lfsr_next;
    logic [TW-1:0] tick_cnt;
    logic [15:0]   phase_ticks;
    logic          tick;
    logic [7:0]    good, bad, remaining;
    logic [7:0]    score_next, misses_press, misses_timeout;

    function automatic logic [3:0] popcnt(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [7:0] sat8(input logic [9:0] v);
        return (v > 10'd255) ? 8'hFF : v[7:0];
    endfunction

    assign start_edge = start_s2 & ~start_prev;
    assign press      = btn_s2 & ~btn_prev;
    assign lfsr_next  = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    assign tick       = (tick_cnt == TW'(TICK_DIV - 1));

    // Two-flop synchronisers plus previous-value flops for rising-edge detection
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_prev <= 1'b0;
            btn_s1     <= 8'h00;
            btn_s2     <= 8'h00;
            btn_prev   <= 8'h00;
        end else begin
            start_s1   <= start;
            start_s2   <= start_s1;
            start_prev <= start_s2;
            btn_s1     <= btn;
            btn_s2     <= btn_s1;
            btn_prev   <= btn_s2;
        end
    end

    // Classify this cycle's presses and precompute the saturated totals
    always_comb begin
        good           = press & random_num;
        bad            = press & ~random_num & ~hit;
        remaining      = random_num & ~good;
        score_next     = sat8({2'b00, score} + {6'b000000, popcnt(good)});
        misses_press   = sat8({2'b00, misses} + {6'b000000, popcnt(bad)});
        misses_timeout = sat8({2'b00, misses} + {6'b000000, popcnt(bad)}
                              + {6'b000000, popcnt(remaining)});
    end

    // Target pattern generator: steps every clock or only at spawn depending on build
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            lfsr <= LFSR_SEED;
        end else begin
`ifdef MOLE_FREERUN_LFSR_EN
            lfsr <= lfsr_next;
`else
            if (state == SPAWN) lfsr <= lfsr_next;
`endif
        end
    end

    // Game sequencer with registered outputs, tick divider and phase tick counter
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state       <= IDLE;
            random_num  <= 8'h00;
            hit         <= 8'h00;
            score       <= 8'h00;
            misses      <= 8'h00;
            round_idx   <= 8'h00;
            game_over   <= 1'b0;
            tick_cnt    <= '0;
            phase_ticks <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) state <= SPAWN;
                end
                SPAWN: begin
                    random_num  <= lfsr;
                    hit         <= 8'h00;
                    tick_cnt    <= '0;
                    phase_ticks <= 16'd0;
                    state       <= ACTIVE;
                end
                ACTIVE: begin
                    if (tick) begin
                        tick_cnt    <= '0;
                        phase_ticks <= phase_ticks + 16'd1;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                    random_num <= remaining;
                    hit        <= hit | good;
                    score      <= score_next;
                    if (phase_ticks == 16'(ROUND_TICKS)) begin
                        misses      <= misses_timeout;
                        phase_ticks <= 16'd0;
                        state       <= REVEAL;
                    end else begin
                        misses <= misses_press;
                        if (remaining == 8'h00) begin
                            phase_ticks <= 16'd0;
                            state       <= REVEAL;
                        end
                    end
                end
                REVEAL: begin
                    if (phase_ticks == 16'(REVEAL_TICKS)) begin
                        phase_ticks <= 16'd0;
                        if (round_idx == 8'(ROUNDS - 1)) begin
                            random_num <= 8'h00;
                            hit        <= 8'hFF;
                            game_over  <= 1'b1;
                            state      <= GAMEOVER;
                        end else begin
                            round_idx <= round_idx + 8'd1;
                            state     <= SPAWN;
                        end
                    end else if (tick) begin
                        tick_cnt    <= '0;
                        phase_ticks <= phase_ticks + 16'd1;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                GAMEOVER: begin
                    if (start_edge) begin
                        score     <= 8'h00;
                        misses    <= 8'h00;
                        round_idx <= 8'h00;
                        game_over <= 1'b0;
                        state     <= SPAWN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
